// File: rtl/instruction_sequencer_pkg.sv
// rtl/instruction_sequencer_pkg.sv - shared control-word masks and sequencer state encoding
package instruction_sequencer_pkg;

    localparam int CONTROL_WORD_WIDTH = 16;

    localparam logic [CONTROL_WORD_WIDTH-1:0] c_HLT = 16'h0001;
    localparam logic [CONTROL_WORD_WIDTH-1:0] c_ADV = 16'h0002;
    localparam logic [CONTROL_WORD_WIDTH-1:0] c_II  = 16'h0004;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    typedef enum logic [1:0] {
        S_RUN   = ST_RUN,
        S_HALT  = ST_HALT,
        S_FAULT = ST_FAULT
    } seq_state_e;

endpackage

// File: rtl/instruction_sequencer_step_counter.sv
// rtl/instruction_sequencer_step_counter.sv - micro-step counter with enable, clear and terminal count
module instruction_sequencer_step_counter #(
    parameter int INSTRUCTION_STEPS = 32,
    parameter int STEP_WIDTH        = $clog2(INSTRUCTION_STEPS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic                  i_clear,
    output logic [STEP_WIDTH-1:0] o_count,
    output logic                  o_terminal
);

    logic [STEP_WIDTH-1:0] r_count;

    // Clear dominates enable so an advance always lands on step 0.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == STEP_WIDTH'(INSTRUCTION_STEPS - 1));

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - run/halt/fault sequencer owning the instruction register and step counter
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int INSTRUCTION_STEPS = 32,
    parameter int RETIRED_WIDTH     = 32,
    parameter int STEP_WIDTH        = $clog2(INSTRUCTION_STEPS)
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [CONTROL_WORD_WIDTH-1:0] i_control_word,
    input  logic [INSTRUCTION_WIDTH-1:0]  i_bus,
    input  logic                          i_run,
    input  logic                          i_step_pulse,
    input  logic                          i_resume,
    output logic [STEP_WIDTH-1:0]         o_step,
    output logic [INSTRUCTION_WIDTH-1:0]  o_instruction,
    output logic                          o_cycle_en,
    output logic                          o_halted,
    output logic                          o_fault,
    output logic [RETIRED_WIDTH-1:0]      o_retired
);

    seq_state_e                 r_state;
    logic [INSTRUCTION_WIDTH-1:0] r_instruction;
    logic [RETIRED_WIDTH-1:0]     r_retired;

    logic w_cycle_en;
    logic w_hlt;
    logic w_adv;
    logic w_ii;
    logic w_terminal;
    logic w_resume;
    logic w_step_en;
    logic w_step_clear;

    assign w_hlt = |(i_control_word & c_HLT);
    assign w_adv = |(i_control_word & c_ADV);
    assign w_ii  = |(i_control_word & c_II);

    assign w_cycle_en = (r_state == S_RUN) & (i_run | i_step_pulse);
    assign w_resume   = (r_state == S_HALT) & i_resume;

    // HLT freezes the step; a runaway step at terminal count also freezes it.
    assign w_step_clear = (w_cycle_en & ~w_hlt & w_adv) | w_resume;
    assign w_step_en    = w_cycle_en & ~w_hlt & ~w_adv & ~w_terminal;

    instruction_sequencer_step_counter #(
        .INSTRUCTION_STEPS (INSTRUCTION_STEPS),
        .STEP_WIDTH        (STEP_WIDTH)
    ) u_step_counter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_en       (w_step_en),
        .i_clear    (w_step_clear),
        .o_count    (o_step),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_RUN;
            r_instruction <= '0;
            r_retired     <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_cycle_en) begin
                        if (w_ii) begin
                            r_instruction <= i_bus;
                        end
                        if (w_hlt) begin
                            r_state <= S_HALT;
                        end else if (w_adv) begin
                            r_retired <= r_retired + 1'b1;
                        end else if (w_terminal) begin
                            r_state <= S_FAULT;
                        end
                    end
                end
                S_HALT: begin
                    // The halting instruction is counted as retired on resume.
                    if (i_resume) begin
                        r_state   <= S_RUN;
                        r_retired <= r_retired + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_FAULT;
                end
            endcase
        end
    end

    assign o_cycle_en    = w_cycle_en;
    assign o_instruction = r_instruction;
    assign o_retired     = r_retired;
    assign o_halted      = (r_state == S_HALT);
    assign o_fault       = (r_state == S_FAULT);

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - directed self-checking bench for instruction_sequencer
module tb_instruction_sequencer;
    import instruction_sequencer_pkg::*;

    logic                          clk = 1'b0;
    logic                          i_reset = 1'b0;
    logic [CONTROL_WORD_WIDTH-1:0] i_control_word;
    logic [15:0]                   i_bus = '0;
    logic                          i_run = 1'b0;
    logic                          i_step_pulse = 1'b0;
    logic                          i_resume = 1'b0;
    logic [4:0]                    o_step;
    logic [15:0]                   o_instruction;
    logic                          o_cycle_en;
    logic                          o_halted;
    logic                          o_fault;
    logic [31:0]                   o_retired;

    int checks = 0;
    int errors = 0;

    // Stand-in decoder: which step raises ADV, II and HLT (-1 = never).
    int adv_step = 2;
    int ii_step  = -1;
    int hlt_step = -1;

    assign i_control_word = ((int'(o_step) == adv_step) ? c_ADV : '0)
                          | ((int'(o_step) == ii_step)  ? c_II  : '0)
                          | ((int'(o_step) == hlt_step) ? c_HLT : '0);

    always #5 clk = ~clk;

    instruction_sequencer dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_control_word (i_control_word),
        .i_bus          (i_bus),
        .i_run          (i_run),
        .i_step_pulse   (i_step_pulse),
        .i_resume       (i_resume),
        .o_step         (o_step),
        .o_instruction  (o_instruction),
        .o_cycle_en     (o_cycle_en),
        .o_halted       (o_halted),
        .o_fault        (o_fault),
        .o_retired      (o_retired)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        i_run = 1'b0;
        i_step_pulse = 1'b0;
        i_resume = 1'b0;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        adv_step = 2; ii_step = -1; hlt_step = -1;
        apply_reset();
        #1;
        checks++; if (o_step !== 5'd0) begin errors++; $display("FAIL reset_step got %0d exp 0", o_step); end
        checks++; if (o_instruction !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h exp 0000", o_instruction); end
        checks++; if (o_halted !== 1'b0 || o_fault !== 1'b0) begin errors++; $display("FAIL reset_flags got h=%b f=%b exp 0 0", o_halted, o_fault); end
        checks++; if (o_retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d exp 0", o_retired); end
        checks++; if (o_cycle_en !== 1'b0) begin errors++; $display("FAIL reset_cycle_en got %b exp 0", o_cycle_en); end
    endtask

    task automatic test_free_run();
        adv_step = 2; ii_step = -1; hlt_step = -1;
        apply_reset();
        i_run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++; if (o_step !== 5'(i % 3)) begin errors++; $display("FAIL free_run_step[%0d] got %0d exp %0d", i, o_step, i % 3); end
            tick();
        end
        checks++; if (o_retired !== 32'd3) begin errors++; $display("FAIL free_run_retired got %0d exp 3", o_retired); end
        i_run = 1'b0;
    endtask

    task automatic test_fetch();
        adv_step = 3; ii_step = 1; hlt_step = -1;
        apply_reset();
        i_bus = 16'h002a;
        i_run = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (o_instruction !== 16'h002a) begin errors++; $display("FAIL fetch_instr got %h exp 002a", o_instruction); end
        checks++; if (o_step !== 5'd2) begin errors++; $display("FAIL fetch_step got %0d exp 2", o_step); end
        i_bus = 16'h5555;
        tick();
        tick();
        #1;
        checks++; if (o_step !== 5'd0) begin errors++; $display("FAIL fetch_adv_step got %0d exp 0", o_step); end
        checks++; if (o_retired !== 32'd1) begin errors++; $display("FAIL fetch_retired got %0d exp 1", o_retired); end
        checks++; if (o_instruction !== 16'h002a) begin errors++; $display("FAIL fetch_instr_hold got %h exp 002a", o_instruction); end
        i_run = 1'b0;
    endtask

    task automatic test_step_mode();
        logic [4:0] exp_step;
        adv_step = 2; ii_step = -1; hlt_step = -1;
        apply_reset();
        exp_step = 5'd0;
        for (int c = 0; c < 12; c++) begin
            i_step_pulse = (c == 5 || c == 9);
            #1;
            checks++; if (o_cycle_en !== i_step_pulse) begin errors++; $display("FAIL step_cycle_en[%0d] got %b exp %b", c, o_cycle_en, (c == 5 || c == 9)); end
            tick();
            i_step_pulse = 1'b0;
            if (c == 5 || c == 9) exp_step = exp_step + 5'd1;
            #1;
            checks++; if (o_step !== exp_step) begin errors++; $display("FAIL step_step[%0d] got %0d exp %0d", c, o_step, exp_step); end
        end
    endtask

    task automatic test_halt();
        adv_step = 2; ii_step = -1; hlt_step = 2;
        apply_reset();
        i_run = 1'b1;
        tick();
        tick();
        tick();
        for (int c = 0; c < 20; c++) begin
            i_step_pulse = (c == 7);
            #1;
            checks++; if (o_halted !== 1'b1 || o_step !== 5'd2 || o_cycle_en !== 1'b0) begin
                errors++; $display("FAIL halt_hold[%0d] got h=%b s=%0d en=%b exp 1 2 0", c, o_halted, o_step, o_cycle_en);
            end
            tick();
        end
        i_step_pulse = 1'b0;
        checks++; if (o_retired !== 32'd0) begin errors++; $display("FAIL halt_retired got %0d exp 0", o_retired); end
        i_resume = 1'b1;
        tick();
        i_resume = 1'b0;
        i_run = 1'b0;
        #1;
        checks++; if (o_halted !== 1'b0 || o_step !== 5'd0) begin errors++; $display("FAIL resume_state got h=%b s=%0d exp 0 0", o_halted, o_step); end
        checks++; if (o_retired !== 32'd1) begin errors++; $display("FAIL resume_retired got %0d exp 1", o_retired); end
    endtask

    task automatic test_reset_vs_resume();
        adv_step = 2; ii_step = -1; hlt_step = 0;
        apply_reset();
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
        #1;
        checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL rvr_halted got %b exp 1", o_halted); end
        i_resume = 1'b1;
        i_reset = 1'b1;
        tick();
        i_resume = 1'b0;
        i_reset = 1'b0;
        #1;
        checks++; if (o_halted !== 1'b0 || o_retired !== 32'd0) begin errors++; $display("FAIL rvr_reset_wins got h=%b r=%0d exp 0 0", o_halted, o_retired); end
    endtask

    task automatic test_fault();
        adv_step = -1; ii_step = -1; hlt_step = -1;
        apply_reset();
        i_run = 1'b1;
        for (int c = 0; c < 31; c++) tick();
        #1;
        checks++; if (o_step !== 5'd31 || o_fault !== 1'b0) begin errors++; $display("FAIL fault_pre got s=%0d f=%b exp 31 0", o_step, o_fault); end
        tick();
        #1;
        checks++; if (o_step !== 5'd31 || o_fault !== 1'b1) begin errors++; $display("FAIL fault_set got s=%0d f=%b exp 31 1", o_step, o_fault); end
        i_resume = 1'b1;
        i_step_pulse = 1'b1;
        tick();
        tick();
        i_resume = 1'b0;
        i_step_pulse = 1'b0;
        #1;
        checks++; if (o_fault !== 1'b1 || o_step !== 5'd31 || o_cycle_en !== 1'b0) begin
            errors++; $display("FAIL fault_sticky got f=%b s=%0d en=%b exp 1 31 0", o_fault, o_step, o_cycle_en);
        end
        apply_reset();
        #1;
        checks++; if (o_fault !== 1'b0 || o_step !== 5'd0) begin errors++; $display("FAIL fault_clear got f=%b s=%0d exp 0 0", o_fault, o_step); end
    endtask

    task automatic test_reset_mid();
        adv_step = 4; ii_step = 1; hlt_step = -1;
        apply_reset();
        i_bus = 16'h1234;
        i_run = 1'b1;
        tick();
        tick();
        tick();
        #1;
        checks++; if (o_step !== 5'd3 || o_instruction !== 16'h1234) begin errors++; $display("FAIL mid_pre got s=%0d i=%h exp 3 1234", o_step, o_instruction); end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        i_run = 1'b0;
        #1;
        checks++; if (o_step !== 5'd0 || o_instruction !== 16'h0000 || o_retired !== 32'd0 || o_halted !== 1'b0 || o_fault !== 1'b0) begin
            errors++; $display("FAIL mid_reset got s=%0d i=%h r=%0d h=%b f=%b exp 0 0000 0 0 0", o_step, o_instruction, o_retired, o_halted, o_fault);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_fetch();
        test_step_mode();
        test_halt();
        test_reset_vs_resume();
        test_fault();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
